// File: rtl/cpu_pkg.sv
// Shared Mini SRC datapath definitions: widths, branch-resolution state
// encoding and the C-field sign-extension helper.
package cpu_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int OFFSET_WIDTH = 19;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_EVAL,
        BR_COMMIT
    } br_state_t;

    function automatic logic [DATA_WIDTH-1:0] sext_offset(input logic [OFFSET_WIDTH-1:0] off);
        return {{(DATA_WIDTH-OFFSET_WIDTH){off[OFFSET_WIDTH-1]}}, off};
    endfunction

endpackage

// File: rtl/br_resolve_fsm.sv
// Branch resolution sequencer: captures the offset, samples the CON FF
// condition one cycle later, and flags the commit cycle.
module br_resolve_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 19
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic                    br_req,
    input  logic                    br_always,
    input  logic                    br_cond,
    input  logic [OFFSET_WIDTH-1:0] br_offset,
    output br_state_t               state,
    output logic [DATA_WIDTH-1:0]   off_r,
    output logic                    take_r,
    output logic                    br_done,
    output logic                    br_taken
);

    br_state_t state_next;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= BR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request arriving outside IDLE is simply not looked at.
    always_comb begin
        state_next = state;
        case (state)
            BR_IDLE:   if (br_req) state_next = BR_EVAL;
            BR_EVAL:   state_next = BR_COMMIT;
            BR_COMMIT: state_next = BR_IDLE;
            default:   state_next = BR_IDLE;
        endcase
    end

    // br_done/br_taken are loaded on the EVAL->COMMIT edge, so they are high
    // for exactly the COMMIT cycle and cleared on every other edge.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            off_r    <= '0;
            take_r   <= 1'b0;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
        end else begin
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            if (state == BR_IDLE && br_req) begin
                off_r <= {{(DATA_WIDTH-OFFSET_WIDTH){br_offset[OFFSET_WIDTH-1]}}, br_offset};
            end
            if (state == BR_EVAL) begin
                take_r   <= br_always | br_cond;
                br_done  <= 1'b1;
                br_taken <= br_always | br_cond;
            end
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter and link register for Mini SRC, with the PC write
// priority mux arbitrating bus loads, jumps, branch commits and fetch increment.
module pc_branch_unit
    import cpu_pkg::*;
#(
    parameter int                   DATA_WIDTH   = 32,
    parameter int                   OFFSET_WIDTH = 19,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic [DATA_WIDTH-1:0]   bus_in,
    input  logic                    pc_in,
    input  logic                    inc_req,
    input  logic                    br_req,
    input  logic                    br_always,
    input  logic                    br_cond,
    input  logic [OFFSET_WIDTH-1:0] br_offset,
    input  logic                    jump_req,
    input  logic                    jump_link,
    input  logic [DATA_WIDTH-1:0]   jump_target,
    output logic [DATA_WIDTH-1:0]   pc_out,
    output logic [DATA_WIDTH-1:0]   link_pc,
    output logic                    busy,
    output logic                    br_done,
    output logic                    br_taken
);

    br_state_t               br_state;
    logic [DATA_WIDTH-1:0]   off_r;
    logic                    take_r;
    logic                    commit_take;

    br_resolve_fsm #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OFFSET_WIDTH (OFFSET_WIDTH)
    ) u_fsm (
        .clk       (clk),
        .clear_n   (clear_n),
        .br_req    (br_req),
        .br_always (br_always),
        .br_cond   (br_cond),
        .br_offset (br_offset),
        .state     (br_state),
        .off_r     (off_r),
        .take_r    (take_r),
        .br_done   (br_done),
        .br_taken  (br_taken)
    );

    assign busy        = (br_state != BR_IDLE);
    assign commit_take = (br_state == BR_COMMIT) && take_r;

    // Losing requests are dropped outright; the branch FSM still retires.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            pc_out <= RESET_PC;
        end else if (pc_in) begin
            pc_out <= bus_in;
        end else if (jump_req) begin
            pc_out <= jump_target;
        end else if (commit_take) begin
            pc_out <= pc_out + off_r;
        end else if (inc_req) begin
            pc_out <= pc_out + 1'b1;
        end
    end

    // The link is captured only when the jump actually wins the PC write.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            link_pc <= '0;
        end else if (jump_req && jump_link && !pc_in) begin
            link_pc <= pc_out;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit: behavioural reference model plus
// per-cycle compare and hand-computed literal expectations.
module tb_pc_branch_unit;

    localparam int DW = 32;
    localparam int OW = 19;

    logic          clk;
    logic          clear_n;
    logic [DW-1:0] bus_in;
    logic          pc_in;
    logic          inc_req;
    logic          br_req;
    logic          br_always;
    logic          br_cond;
    logic [OW-1:0] br_offset;
    logic          jump_req;
    logic          jump_link;
    logic [DW-1:0] jump_target;
    logic [DW-1:0] pc_out;
    logic [DW-1:0] link_pc;
    logic          busy;
    logic          br_done;
    logic          br_taken;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    pc_branch_unit #(
        .DATA_WIDTH   (DW),
        .OFFSET_WIDTH (OW),
        .RESET_PC     (32'h0)
    ) dut (
        .clk         (clk),
        .clear_n     (clear_n),
        .bus_in      (bus_in),
        .pc_in       (pc_in),
        .inc_req     (inc_req),
        .br_req      (br_req),
        .br_always   (br_always),
        .br_cond     (br_cond),
        .br_offset   (br_offset),
        .jump_req    (jump_req),
        .jump_link   (jump_link),
        .jump_target (jump_target),
        .pc_out      (pc_out),
        .link_pc     (link_pc),
        .busy        (busy),
        .br_done     (br_done),
        .br_taken    (br_taken)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a branch is a countdown of remaining cycles plus the
    // decision taken when the condition is sampled.
    logic [DW-1:0] m_pc, m_link, m_off;
    int            m_left;
    bit            m_take;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_pc   <= 32'h0;
            m_link <= 32'h0;
            m_off  <= 32'h0;
            m_left <= 0;
            m_take <= 1'b0;
        end else begin
            if (pc_in)
                m_pc <= bus_in;
            else if (jump_req)
                m_pc <= jump_target;
            else if (m_left == 1 && m_take)
                m_pc <= m_pc + m_off;
            else if (inc_req)
                m_pc <= m_pc + 32'd1;
            if (!pc_in && jump_req && jump_link)
                m_link <= m_pc;
            if (m_left == 0 && br_req) begin
                m_left <= 2;
                m_off  <= unsigned'(32'(signed'(br_offset)));
            end else if (m_left == 2) begin
                m_left <= 1;
                m_take <= br_always | br_cond;
            end else if (m_left == 1) begin
                m_left <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, every cycle away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc_out", pc_out, m_pc);
            check("link_pc", link_pc, m_link);
            check("busy", 32'(busy), 32'(m_left != 0));
            check("br_done", 32'(br_done), 32'(m_left == 1));
            check("br_taken", 32'(br_taken), 32'(m_left == 1 && m_take));
        end
    end

    // driver tasks
    task automatic idle_inputs();
        bus_in = '0; pc_in = 1'b0; inc_req = 1'b0; br_req = 1'b0;
        br_always = 1'b0; br_cond = 1'b0; br_offset = '0;
        jump_req = 1'b0; jump_link = 1'b0; jump_target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic load_pc(input logic [DW-1:0] v);
        idle_inputs();
        pc_in = 1'b1; bus_in = v;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        clear_n = 1'b0;
        chk_en  = 1'b1;
        tick();
        tick();
        check("reset_pc", pc_out, 32'h0);
        check("reset_link", link_pc, 32'h0);
        clear_n = 1'b1;
        tick();

        // 1: reset while the FSM is in EVAL
        load_pc(32'h300);
        br_req = 1'b1; br_cond = 1'b1; br_offset = 19'h4;
        tick();
        idle_inputs();
        check("t1_busy_eval", 32'(busy), 32'h1);
        #2 clear_n = 1'b0;
        #1;
        check("t1_busy_async", 32'(busy), 32'h0);
        check("t1_pc_async", pc_out, 32'h0);
        @(negedge clk);
        clear_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_no_done", 32'(br_done), 32'h0);
        end

        // 2: increment wraps through all-ones
        load_pc(32'hFFFF_FFFE);
        inc_req = 1'b1;
        tick(); check("t2_inc0", pc_out, 32'hFFFF_FFFF);
        tick(); check("t2_inc1", pc_out, 32'h0);
        tick(); check("t2_inc2", pc_out, 32'h1);
        idle_inputs();

        // 3: taken branch, offset -1
        load_pc(32'h100);
        br_req = 1'b1; br_cond = 1'b1; br_offset = 19'h7FFFF;
        tick();
        br_req = 1'b0;
        tick();
        check("t3_done", 32'(br_done), 32'h1);
        check("t3_taken", 32'(br_taken), 32'h1);
        check("t3_pc_hold", pc_out, 32'h100);
        idle_inputs();
        tick();
        check("t3_pc", pc_out, 32'hFF);
        check("t3_done_clr", 32'(br_done), 32'h0);

        // 4: not taken
        load_pc(32'h100);
        br_req = 1'b1; br_offset = 19'h00010;
        tick();
        br_req = 1'b0;
        tick();
        check("t4_done", 32'(br_done), 32'h1);
        check("t4_taken", 32'(br_taken), 32'h0);
        idle_inputs();
        tick();
        check("t4_pc", pc_out, 32'h100);

        // 5: pc_in beats the commit; br_req during busy ignored
        load_pc(32'h100);
        br_req = 1'b1; br_cond = 1'b1; br_offset = 19'h20;
        tick();
        br_offset = 19'h8;
        tick();
        br_req = 1'b0;
        check("t5_done", 32'(br_done), 32'h1);
        pc_in = 1'b1; bus_in = 32'h40;
        tick();
        idle_inputs();
        check("t5_pc", pc_out, 32'h40);
        check("t5_idle", 32'(busy), 32'h0);
        tick();
        tick();
        check("t5_no_requeue", pc_out, 32'h40);

        // 6: jal drops same-cycle inc_req
        load_pc(32'h20);
        jump_req = 1'b1; jump_link = 1'b1; jump_target = 32'h500; inc_req = 1'b1;
        tick();
        idle_inputs();
        check("t6_pc", pc_out, 32'h500);
        check("t6_link", link_pc, 32'h20);

        // unconditional branch wraps past all-ones
        load_pc(32'hFFFF_FFF0);
        br_req = 1'b1; br_always = 1'b1; br_offset = 19'h20;
        tick();
        br_req = 1'b0;
        tick();
        idle_inputs();
        tick();
        check("t7_wrap", pc_out, 32'h10);

        // jump beats commit; link taken from pre-jump PC
        load_pc(32'h80);
        br_req = 1'b1; br_cond = 1'b1; br_offset = 19'h4;
        tick();
        idle_inputs();
        tick();
        jump_req = 1'b1; jump_link = 1'b1; jump_target = 32'h900;
        tick();
        idle_inputs();
        check("t8_pc", pc_out, 32'h900);
        check("t8_link", link_pc, 32'h80);

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
